// File: rtl/score_display_seq.sv
// score_display_seq - iterative double-dabble binary-to-BCD converter with registered 7-segment outputs.
// Each CONVERT cycle performs one add-3/shift step; results, overflow and segments are registered together on the last one.
module score_display_seq #(
  parameter int BIN_W          = 10,
  parameter int DIGITS         = 4,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  function automatic int scratch_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'b0111111;
      4'd1:    seg_lut = 7'b0000110;
      4'd2:    seg_lut = 7'b1011011;
      4'd3:    seg_lut = 7'b1001111;
      4'd4:    seg_lut = 7'b1100110;
      4'd5:    seg_lut = 7'b1101101;
      4'd6:    seg_lut = 7'b1111101;
      4'd7:    seg_lut = 7'b0000111;
      4'd8:    seg_lut = 7'b1111111;
      4'd9:    seg_lut = 7'b1101111;
      default: seg_lut = 7'b0000000;
    endcase
  endfunction

  // Walk from the most significant digit down so "all higher digits zero" is a running flag.
  function automatic logic [7*DIGITS-1:0] seg_encode(input logic [4*DIGITS-1:0] bcd,
                                                     input logic ovf);
    logic [7*DIGITS-1:0] r;
    logic                lead;
    logic [6:0]          pat;
    r    = '0;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (bcd[4*d +: 4] != 4'd0) lead = 1'b0;
      if ((BLANK_LZ != 0) && lead && (d > 0) && !ovf) pat = 7'b0000000;
      else pat = seg_lut(bcd[4*d +: 4]);
      if (SEG_ACTIVE_LOW != 0) pat = ~pat;
      r[7*d +: 7] = pat;
    end
    return r;
  endfunction

  localparam int SD = scratch_digits(BIN_W);
  // Scratch never narrower than the output so the result slice is always in range.
  localparam int SW = (SD > DIGITS) ? SD : DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [7*DIGITS-1:0] SEG_RST = seg_encode('0, 1'b0);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t              state, state_nx;
  logic [BIN_W-1:0]    shift_q, shift_nx, sh_sh;
  logic [4*SW-1:0]     scr_q, scr_nx, adj, scr_sh;
  logic [CW-1:0]       cnt_q, cnt_nx;
  logic                res_en;
  logic                ovf_nx;
  logic [4*DIGITS-1:0] bcd_nx;

  always_comb begin
    adj = scr_q;
    for (int d = 0; d < SW; d++) begin
      if (scr_q[4*d +: 4] > 4'd4) adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
    end
    {scr_sh, sh_sh} = {adj, shift_q} << 1;

    ovf_nx = 1'b0;
    for (int d = DIGITS; d < SW; d++) begin
      if (scr_sh[4*d +: 4] != 4'd0) ovf_nx = 1'b1;
    end
    bcd_nx = ovf_nx ? {DIGITS{4'h9}} : scr_sh[4*DIGITS-1:0];
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift_q;
    scr_nx   = scr_q;
    cnt_nx   = cnt_q;
    res_en   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          shift_nx = bin_in;
          scr_nx   = '0;
          cnt_nx   = CW'(BIN_W);
          state_nx = CONVERT;
        end
      end
      CONVERT: begin
        shift_nx = sh_sh;
        scr_nx   = scr_sh;
        cnt_nx   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_en   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      seg_out  <= SEG_RST;
    end else begin
      state   <= state_nx;
      shift_q <= shift_nx;
      scr_q   <= scr_nx;
      cnt_q   <= cnt_nx;
      done    <= res_en;
      if (res_en) begin
        overflow <= ovf_nx;
        bcd_out  <= bcd_nx;
        seg_out  <= seg_encode(bcd_nx, ovf_nx);
      end
    end
  end

  assign busy = (state == CONVERT);

endmodule

// File: tb/tb_score_display_seq.sv
// tb_score_display_seq - randomized checks of two score_display_seq instances against a decimal reference model.
module tb_score_display_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  bin_a = '0, bin_b = '0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] bcd_a;
  logic [27:0] seg_a;
  logic [7:0]  bcd_b;
  logic [13:0] seg_b;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  always #5 clk = ~clk;

  score_display_seq #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .load(load_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a));

  score_display_seq #(.BIN_W(10), .DIGITS(2), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_b), .load(load_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] model_bcd(input int v, input int nd);
    logic [63:0] r = '0;
    bit ov = (v > pow10(nd) - 1);
    for (int i = 0; i < nd; i++) r[4*i +: 4] = ov ? 4'd9 : 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [63:0] model_seg(input int v, input int nd);
    logic [63:0] r = '0;
    bit ov = (v > pow10(nd) - 1);
    int dg;
    for (int i = 0; i < nd; i++) begin
      dg = ov ? 9 : (v / pow10(i)) % 10;
      if (!ov && i > 0 && v < pow10(i)) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = ~seg_tab[dg];
    end
    return r;
  endfunction

  task automatic launch(input bit b, input int v);
    if (b) begin bin_b = 10'(v); load_b = 1'b1; end
    else begin bin_a = 10'(v); load_a = 1'b1; end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(b ? done_b : done_a) && cyc < 60);
    check("done_seen", b ? done_b : done_a, 1'b1);
  endtask

  task automatic check_result(input bit b, input int v);
    int nd = b ? 2 : 4;
    check("bcd", b ? 64'(bcd_b) : 64'(bcd_a), model_bcd(v, nd));
    check("seg", b ? 64'(seg_b) : 64'(seg_a), model_seg(v, nd));
    check("ovf", b ? ovf_b : ovf_a, (v > pow10(nd) - 1) ? 1'b1 : 1'b0);
    check("busy_at_done", b ? busy_b : busy_a, 1'b0);
  endtask

  task automatic convert(input bit b, input int v);
    int cyc;
    launch(b, v);
    check("busy_rise", b ? busy_b : busy_a, 1'b1);
    wait_done(b, cyc);
    check("latency", cyc, 10);
    check_result(b, v);
    @(negedge clk);
    check("done_pulse", b ? done_b : done_a, 1'b0);
  endtask

  initial begin
    int cyc, v;
    repeat (2) @(negedge clk);
    check("rst_seg_a_const", seg_a, 28'hFFFFFC0);
    check("rst_seg_b", seg_b, model_seg(0, 2));
    check("rst_bcd_a", bcd_a, 16'h0);
    check("rst_busy_done", {busy_a, done_a, ovf_a}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {busy_a, done_a, bcd_a}, 18'h0);

    convert(0, 123);
    check("seg_123", seg_a, {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000});

    launch(0, 1023);
    wait_done(0, cyc);
    check_result(0, 1023);
    launch(0, 0);
    wait_done(0, cyc);
    check("b2b_spacing", cyc + 1, 11);
    check_result(0, 0);

    launch(0, 345);
    repeat (3) @(negedge clk);
    launch(0, 7);
    wait_done(0, cyc);
    check("ignored_load_latency", cyc + 4, 10);
    check_result(0, 345);
    @(negedge clk);
    check("ignored_no_second", {done_a, busy_a}, 2'b00);

    convert(1, 150);
    convert(1, 42);
    convert(1, 99);
    convert(1, 100);

    launch(0, 500);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_a, 1'b0);
    check("async_rst_bcd", bcd_a, model_bcd(0, 4));
    check("async_rst_seg", seg_a, 28'hFFFFFC0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a) cyc++;
    end
    check("no_done_after_abort", cyc, 0);
    convert(0, 500);

    for (int i = 0; i < 20; i++) begin
      v = (i == 0) ? 1023 : int'($urandom_range(0, 1023));
      convert(i[0], v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
